mem_ctrl_ram: RTL and testbench

- Parametrised word-addressed RAM with a request/done handshake, programmable wait states, byte-lane write enables and an out-of-range error flag.
- Successor to the team's fixed 128x32 bus-shared memory. Replaces the tristate bus with separate write and read data ports.
- Sits between the MIPS datapath load/store stage and instruction/data storage. The datapath stalls on READY low.

---
 rtl/mem_ctrl_ram.sv | 162 ++++++++++++++++
 tb/tb_mem_ctrl_ram.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_ram.sv
// mem_ctrl_ram
//   Word-addressed RAM behind a request/done handshake. A request is accepted
//   from IDLE when CS is high, optionally waits WAIT_STATES cycles, and then
//   completes with a one-cycle DONE pulse. Writes honour per-byte enables.
//   Addresses at or beyond DEPTH complete normally but flag ERR and never
//   touch the array (no aliasing).
//
// Ports
//   CLK    in   clock, rising edge
//   RST_N  in   asynchronous active-low reset
//   CS     in   request valid (taken only while READY is high)
//   WE     in   1 = write, 0 = read
//   BE     in   byte-lane write enables, bit i -> bits [8i+7:8i]
//   ADDR   in   word address
//   WDATA  in   write data
//   READY  out  high when a request can be accepted (IDLE)
//   DONE   out  one-cycle completion pulse
//   RDATA  out  read data, valid with DONE and held until the next read
//   ERR    out  pulses with DONE when the address was out of range
module mem_ctrl_ram #(
  parameter int    DATA_W      = 32,
  parameter int    ADDR_W      = 7,
  parameter int    DEPTH       = 128,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                CS,
  input  logic                WE,
  input  logic [DATA_W/8-1:0] BE,
  input  logic [ADDR_W-1:0]   ADDR,
  input  logic [DATA_W-1:0]   WDATA,
  output logic                READY,
  output logic                DONE,
  output logic [DATA_W-1:0]   RDATA,
  output logic                ERR
);

  localparam int              NB       = DATA_W / 8;
  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam bit              HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [3:0]      WS_LOAD  = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_cnt;

  logic                r_we;
  logic [NB-1:0]       r_be;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_accept;
  logic                w_enter_resp;
  logic                w_op_we;
  logic [NB-1:0]       w_op_be;
  logic [ADDR_W-1:0]   w_op_addr;
  logic [DATA_W-1:0]   w_op_wdata;
  logic                w_in_range;
  logic [IDX_W-1:0]    w_idx;

  // Power-up image of the array. Reset never clears it, so this is the only
  // place contents are defined before the first write.
  initial begin
    for (int i = 0; i < DEPTH; i++) r_mem[i] = '0;
  end

  assign w_accept     = (r_state == S_IDLE) && CS;
  assign w_enter_resp = (w_state_nxt == S_RESP);

  // With no wait states the access happens on the accepting edge itself, so
  // the operation must come straight from the inputs; otherwise it comes from
  // the request captured at accept time.
  assign w_op_we    = (r_state == S_IDLE) ? WE    : r_we;
  assign w_op_be    = (r_state == S_IDLE) ? BE    : r_be;
  assign w_op_addr  = (r_state == S_IDLE) ? ADDR  : r_addr;
  assign w_op_wdata = (r_state == S_IDLE) ? WDATA : r_wdata;

  assign w_in_range = ({1'b0, w_op_addr} < DEPTH_L);
  assign w_idx      = w_op_addr[IDX_W-1:0];

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    READY       = 1'b0;
    DONE        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        READY = 1'b1;
        if (CS) w_state_nxt = HAS_WAIT ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        DONE        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_accept) begin
        r_we    <= WE;
        r_be    <= BE;
        r_addr  <= ADDR;
        r_wdata <= WDATA;
        r_cnt   <= WS_LOAD;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end

      // RESP lasts exactly one cycle, so ERR self-clears on the next edge.
      r_err <= w_enter_resp && !w_in_range;

      if (w_enter_resp && !w_op_we) r_rdata <= w_in_range ? r_mem[w_idx] : '0;
    end
  end

  // NOTE: the array has no reset branch on purpose; contents survive reset
  // and the block maps onto plain RAM. RST_N still gates the write so an
  // aborted request can never commit.
  always_ff @(posedge CLK) begin
    if (RST_N && w_enter_resp && w_op_we && w_in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (w_op_be[b]) r_mem[w_idx][8*b +: 8] <= w_op_wdata[8*b +: 8];
      end
    end
  end

  assign RDATA = r_rdata;
  assign ERR   = r_err;

endmodule

// File: tb/tb_mem_ctrl_ram.sv
// Bench for mem_ctrl_ram. Two instances:
//   A: defaults (DEPTH=128, WAIT_STATES=0)
//   B: DEPTH=100, WAIT_STATES=3 (out-of-range, wait timing, reset abort)
// Every issued request pushes its expected {RDATA, ERR} into a per-instance
// queue; a monitor pops and compares whenever that instance shows DONE.
module tb_mem_ctrl_ram;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n_a, rst_n_b;

  logic        a_cs, a_we, a_ready, a_done, a_err;
  logic [3:0]  a_be;
  logic [6:0]  a_addr;
  logic [31:0] a_wdata, a_rdata;

  logic        b_cs, b_we, b_ready, b_done, b_err;
  logic [3:0]  b_be;
  logic [6:0]  b_addr;
  logic [31:0] b_wdata, b_rdata;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   last_acc;
  int   acc [4];
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_ctrl_ram u_a (
    .CLK(clk), .RST_N(rst_n_a), .CS(a_cs), .WE(a_we), .BE(a_be),
    .ADDR(a_addr), .WDATA(a_wdata), .READY(a_ready), .DONE(a_done),
    .RDATA(a_rdata), .ERR(a_err)
  );

  mem_ctrl_ram #(.DATA_W(32), .ADDR_W(7), .DEPTH(100), .WAIT_STATES(3)) u_b (
    .CLK(clk), .RST_N(rst_n_b), .CS(b_cs), .WE(b_we), .BE(b_be),
    .ADDR(b_addr), .WDATA(b_wdata), .READY(b_ready), .DONE(b_done),
    .RDATA(b_rdata), .ERR(b_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitors: one per instance, sampling on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (a_done === 1'b1) begin
      if (q_a.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL a_unexpected_done: got DONE=1, expected no completion");
      end else begin
        e = q_a.pop_front();
        check("a_rdata", a_rdata, e.rdata);
        check("a_err", {31'b0, a_err}, {31'b0, e.err});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_done === 1'b1) begin
      if (q_b.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL b_unexpected_done: got DONE=1, expected no completion");
      end else begin
        e = q_b.pop_front();
        check("b_rdata", b_rdata, e.rdata);
        check("b_err", {31'b0, b_err}, {31'b0, e.err});
      end
    end
  end

  // Wait for READY, present a request, let one edge accept it.
  task automatic issue(input bit sel, input logic we, input logic [3:0] be,
                       input logic [6:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input bit push, input bit hold_cs);
    bit   got = 1'b0;
    exp_t e;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((sel ? b_ready : a_ready) === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL ready_timeout: got READY=0 for 100 cycles, expected READY=1");
      return;
    end
    e.rdata = exp_rd;
    e.err   = exp_err;
    if (sel) begin
      b_cs = 1'b1; b_we = we; b_be = be; b_addr = addr; b_wdata = wd;
      if (push) q_b.push_back(e);
    end else begin
      a_cs = 1'b1; a_we = we; a_be = be; a_addr = addr; a_wdata = wd;
      if (push) q_a.push_back(e);
    end
    @(posedge clk);
    #1;
    last_acc = cyc;
    if (sel) begin
      if (!hold_cs) b_cs = 1'b0;
      check("b_ready_drop", {31'b0, b_ready}, 32'd0);
    end else begin
      if (!hold_cs) a_cs = 1'b0;
      check("a_ready_drop", {31'b0, a_ready}, 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    a_cs = 1'b0; a_we = 1'b0; a_be = '0; a_addr = '0; a_wdata = '0;
    b_cs = 1'b0; b_we = 1'b0; b_be = '0; b_addr = '0; b_wdata = '0;

    repeat (3) @(negedge clk);
    check("a_rst_ready", {31'b0, a_ready}, 32'd1);
    check("a_rst_done",  {31'b0, a_done},  32'd0);
    check("a_rst_err",   {31'b0, a_err},   32'd0);
    check("a_rst_rdata", a_rdata,          32'd0);
    check("b_rst_ready", {31'b0, b_ready}, 32'd1);
    check("b_rst_rdata", b_rdata,          32'd0);
    rst_n_a = 1'b1; rst_n_b = 1'b1;

    // ---------------- Instance A: zero wait states ----------------
    issue(0, 1'b0, 4'hF, 7'd5, 32'h0, 32'h0000_0000, 1'b0, 1, 0);
    @(negedge clk);
    check("a_done_latency", {31'b0, a_done}, 32'd1);

    issue(0, 1'b1, 4'hF,    7'd10, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1, 0);
    issue(0, 1'b0, 4'hF,    7'd10, 32'h0,         32'hDEAD_BEEF, 1'b0, 1, 0);
    issue(0, 1'b1, 4'b0101, 7'd10, 32'h1122_3344, 32'hDEAD_BEEF, 1'b0, 1, 0);
    issue(0, 1'b0, 4'b0000, 7'd10, 32'h0,         32'hDE22_BE44, 1'b0, 1, 0);
    // All-zero byte enables: completes, array unchanged.
    issue(0, 1'b1, 4'b0000, 7'd10, 32'h0,         32'hDE22_BE44, 1'b0, 1, 0);
    issue(0, 1'b0, 4'hF,    7'd10, 32'h0,         32'hDE22_BE44, 1'b0, 1, 0);

    // CS held high: alternating write/read of address 7.
    issue(0, 1'b1, 4'hF, 7'd7, 32'h1, 32'hDE22_BE44, 1'b0, 1, 1); acc[0] = last_acc;
    issue(0, 1'b0, 4'hF, 7'd7, 32'h0, 32'h0000_0001, 1'b0, 1, 1); acc[1] = last_acc;
    issue(0, 1'b1, 4'hF, 7'd7, 32'h2, 32'h0000_0001, 1'b0, 1, 1); acc[2] = last_acc;
    issue(0, 1'b0, 4'hF, 7'd7, 32'h0, 32'h0000_0002, 1'b0, 1, 1); acc[3] = last_acc;
    a_cs = 1'b0;
    for (int k = 1; k < 4; k++) check("a_accept_spacing", acc[k] - acc[k-1], 32'd2);

    // ---------------- Instance B: DEPTH=100, WAIT_STATES=3 ----------------
    issue(1, 1'b1, 4'hF, 7'd20, 32'h0BAD_F00D, 32'h0000_0000, 1'b0, 1, 0);
    issue(1, 1'b0, 4'hF, 7'd20, 32'h0,         32'h0BAD_F00D, 1'b0, 1, 0);

    // Wait-state timing; inputs toggled while busy must be ignored.
    issue(1, 1'b0, 4'hF, 7'd20, 32'h0,         32'h0BAD_F00D, 1'b0, 1, 0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("b_ready_cycle%0d", k), {31'b0, b_ready}, (k == 5) ? 32'd1 : 32'd0);
      check($sformatf("b_done_cycle%0d", k),  {31'b0, b_done},  (k == 4) ? 32'd1 : 32'd0);
      if (k <= 4) begin
        b_cs = (k != 2); b_we = 1'b1; b_be = 4'hF; b_addr = 7'd20; b_wdata = 32'h1234_5678;
      end else begin
        b_cs = 1'b0;
      end
    end
    issue(1, 1'b0, 4'hF, 7'd20, 32'h0,         32'h0BAD_F00D, 1'b0, 1, 0);

    // Out of range: flagged, no array update, no alias onto 120-100 or 120-128.
    issue(1, 1'b1, 4'hF, 7'd120, 32'hFFFF_FFFF, 32'h0BAD_F00D, 1'b1, 1, 0);
    issue(1, 1'b0, 4'hF, 7'd120, 32'h0,         32'h0000_0000, 1'b1, 1, 0);
    issue(1, 1'b0, 4'hF, 7'd20,  32'h0,         32'h0BAD_F00D, 1'b0, 1, 0);
    issue(1, 1'b0, 4'hF, 7'd92,  32'h0,         32'h0000_0000, 1'b0, 1, 0);

    // Reset during WAIT aborts the write.
    issue(1, 1'b1, 4'hF, 7'd3, 32'hA5A5_A5A5, 32'h0, 1'b0, 0, 0);
    @(negedge clk);
    rst_n_b = 1'b0;
    #1;
    check("b_abort_ready", {31'b0, b_ready}, 32'd1);
    check("b_abort_done",  {31'b0, b_done},  32'd0);
    check("b_abort_err",   {31'b0, b_err},   32'd0);
    check("b_abort_rdata", b_rdata,          32'd0);
    repeat (2) @(negedge clk);
    rst_n_b = 1'b1;
    issue(1, 1'b0, 4'hF, 7'd3, 32'h0, 32'h0000_0000, 1'b0, 1, 0);

    repeat (10) @(negedge clk);
    check("a_pending_done", q_a.size(), 32'd0);
    check("b_pending_done", q_b.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
